dm_resp: RTL and testbench

Data-memory responder at the MEM stage of the five-stage MIPS pipeline: it consumes the memory request held in the EX/MEM pipeline register (write strobe, load strobe, ALU address, store data) and services it against a word-addressed data RAM with a configurable number of wait states. While a request is in flight it raises `stall` to the hazard unit, which freezes PC, IF/ID, ID/EX and EX/MEM. It returns load data with a one-cycle valid pulse and flags misaligned accesses.

---
 rtl/dm_pkg.sv | 17 +
 rtl/dm_ram.sv | 34 +++
 rtl/dm_resp.sv | 155 +++++++++++++++
 tb/tb_dm_resp.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared types and limits for the MEM-stage data-memory responder
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic {
        OP_LD,
        OP_ST
    } op_t;

    localparam int LAT_MAX = 15;

endpackage

// File: rtl/dm_ram.sv
// rtl/dm_ram.sv - word-addressed data RAM, synchronous write and registered read
//
// Ports:
//   clk    rising-edge clock
//   we     write enable, writes wdata to mem[waddr]
//   waddr  word write address
//   wdata  write data
//   re     read enable, loads mem[raddr] into rdata
//   raddr  word read address
//   rdata  registered read data, holds between reads
module dm_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dm_resp.sv
// rtl/dm_resp.sv - MEM-stage responder: services lw/sw against dm_ram with wait states
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low
//   mem_write  store request from EX/MEM
//   mem_read   load request from EX/MEM
//   addr       byte address
//   wdata      store data
//   stall      pipeline freeze request while an access is in flight
//   rdata      last load result (0 after reset or a misaligned load)
//   rvalid     one-cycle pulse when a load completes
//   align_err  one-cycle pulse when the completed access was misaligned or illegal
module dm_resp
    import dm_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        align_err
);

    localparam int         LAT_C = (LAT > LAT_MAX) ? LAT_MAX : LAT;
    localparam logic [3:0] LAT_V = 4'(LAT_C);

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    op_t               op_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              bad_q;
    logic              rd_zero;
    logic [31:0]       ram_q;
    logic              req;
    logic              commit;

    op_t               cur_op;
    logic [ADDR_W+1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic              cur_bad;
    logic              cur_mis;

    // Upper address bits alias onto the RAM, so they are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^addr[31:ADDR_W+2];

    assign req = mem_write | mem_read;

    // With LAT=0 the commit edge is the capture edge, so the request must be
    // taken straight from the inputs while in IDLE; afterwards only the
    // captured copy is trusted.
    always_comb begin
        cur_op    = op_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_bad   = bad_q;
        if (state == IDLE) begin
            cur_op    = mem_write ? OP_ST : OP_LD;
            cur_addr  = addr[ADDR_W+1:0];
            cur_wdata = wdata;
            cur_bad   = (addr[1:0] != 2'b00) | (mem_write & mem_read);
        end
    end

    assign cur_mis = (cur_addr[1:0] != 2'b00);

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    stall = 1'b1;
                    if (LAT_V == 4'd0) begin
                        state_nx = DONE;
                        commit   = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt <= 4'd1) begin
                    state_nx = DONE;
                    commit   = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op_q      <= OP_LD;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            bad_q     <= 1'b0;
            rd_zero   <= 1'b1;
            rvalid    <= 1'b0;
            align_err <= 1'b0;
        end else begin
            state     <= state_nx;
            rvalid    <= commit & (cur_op == OP_LD);
            align_err <= commit & cur_bad;
            if (state == IDLE && req) begin
                cnt     <= LAT_V;
                op_q    <= cur_op;
                addr_q  <= cur_addr;
                wdata_q <= cur_wdata;
                bad_q   <= cur_bad;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (commit && cur_op == OP_LD) begin
                rd_zero <= cur_mis;
            end
        end
    end

    // The RAM read register only updates on an aligned load commit, so it
    // keeps the last load word; rd_zero masks it after reset or a bad load.
    dm_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (commit & (cur_op == OP_ST) & ~cur_mis),
        .waddr (cur_addr[ADDR_W+1:2]),
        .wdata (cur_wdata),
        .re    (commit & (cur_op == OP_LD) & ~cur_mis),
        .raddr (cur_addr[ADDR_W+1:2]),
        .rdata (ram_q)
    );

    assign rdata = rd_zero ? 32'd0 : ram_q;

endmodule

// File: tb/tb_dm_resp.sv
// tb/tb_dm_resp.sv - scoreboard bench for dm_resp at LAT=2 and LAT=0
module tb_dm_resp;

    typedef struct {
        int          cyc;
        bit          rv;
        bit          ae;
        bit          chk;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_write [2];
    logic        mem_read  [2];
    logic [31:0] addr      [2];
    logic [31:0] wdata     [2];
    logic        stall     [2];
    logic [31:0] rdata     [2];
    logic        rvalid    [2];
    logic        align_err [2];

    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    resp_t exp_q [2][$];
    int    stl_q [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_resp #(.ADDR_W(10), .LAT(2)) u_lat2 (
        .clk(clk), .reset(reset),
        .mem_write(mem_write[0]), .mem_read(mem_read[0]),
        .addr(addr[0]), .wdata(wdata[0]),
        .stall(stall[0]), .rdata(rdata[0]),
        .rvalid(rvalid[0]), .align_err(align_err[0])
    );

    dm_resp #(.ADDR_W(10), .LAT(0)) u_lat0 (
        .clk(clk), .reset(reset),
        .mem_write(mem_write[1]), .mem_read(mem_read[1]),
        .addr(addr[1]), .wdata(wdata[1]),
        .stall(stall[1]), .rdata(rdata[1]),
        .rvalid(rvalid[1]), .align_err(align_err[1])
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Issue one access on DUT i at the current cycle, hold it through DONE.
    task automatic access(input int i, input bit wr, input bit rd,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_data, input bit scr);
        int    lat;
        bit    bad;
        resp_t e;
        lat = (i == 0) ? 2 : 0;
        bad = (a[1:0] != 2'b00) || (wr && rd);
        mem_write[i] = wr;
        mem_read[i]  = rd;
        addr[i]      = a;
        wdata[i]     = d;
        stl_q[i].push_back(lat + 1);
        if ((rd && !wr) || bad) begin
            e.cyc  = cyc + lat + 1;
            e.rv   = rd && !wr;
            e.ae   = bad;
            e.chk  = rd && !wr;
            e.data = exp_data;
            exp_q[i].push_back(e);
        end
        repeat (lat + 2) begin
            @(posedge clk);
            #1;
            if (scr) begin
                addr[i]  = $urandom;
                wdata[i] = $urandom;
            end
        end
        mem_write[i] = 1'b0;
        mem_read[i]  = 1'b0;
    endtask

    // Monitor: stall run lengths and response pulses against the queues.
    initial begin
        int    run [2];
        resp_t e;
        run[0] = 0;
        run[1] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (stall[i] === 1'b1) begin
                    run[i] = run[i] + 1;
                end else if (run[i] > 0) begin
                    if (stl_q[i].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL stall_unexpected dut%0d: run %0d, none expected", i, run[i]);
                    end else begin
                        check($sformatf("stall_len dut%0d", i), 32'(run[i]), 32'(stl_q[i].pop_front()));
                    end
                    run[i] = 0;
                end
                if (rvalid[i] === 1'b1 || align_err[i] === 1'b1) begin
                    if (exp_q[i].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL resp_unexpected dut%0d: rvalid %0b align_err %0b, none expected",
                                 i, rvalid[i], align_err[i]);
                    end else begin
                        e = exp_q[i].pop_front();
                        check($sformatf("resp_cycle dut%0d", i), 32'(cyc), 32'(e.cyc));
                        check($sformatf("rvalid dut%0d", i), 32'(rvalid[i]), 32'(e.rv));
                        check($sformatf("align_err dut%0d", i), 32'(align_err[i]), 32'(e.ae));
                        if (e.chk) begin
                            check($sformatf("rdata dut%0d", i), rdata[i], e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            mem_write[i] = 1'b0;
            mem_read[i]  = 1'b0;
            addr[i]      = 32'd0;
            wdata[i]     = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_stall dut%0d", i), 32'(stall[i]), 32'd0);
            check($sformatf("reset_rvalid dut%0d", i), 32'(rvalid[i]), 32'd0);
            check($sformatf("reset_align_err dut%0d", i), 32'(align_err[i]), 32'd0);
            check($sformatf("reset_rdata dut%0d", i), rdata[i], 32'd0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;

        access(0, 1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1);
        access(0, 0, 1, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0);
        access(0, 1, 0, 32'h0000_0012, 32'h1111_1111, 32'h0, 0);
        access(0, 0, 1, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0);
        access(0, 0, 1, 32'h0000_0013, 32'h0, 32'h0, 0);
        access(0, 1, 0, 32'h0000_1004, 32'hA5A5_A5A5, 32'h0, 0);
        access(0, 0, 1, 32'h0000_0004, 32'h0, 32'hA5A5_A5A5, 0);
        access(0, 1, 0, 32'h0000_0020, 32'h0BAD_F00D, 32'h0, 0);

        // Store aborted by reset during its first WAIT cycle.
        mem_write[0] = 1'b1;
        addr[0]      = 32'h0000_0020;
        wdata[0]     = 32'hFFFF_FFFF;
        stl_q[0].push_back(1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_write[0] = 1'b0;
        #1;
        check("midreset_stall", 32'(stall[0]), 32'd0);
        check("midreset_rvalid", 32'(rvalid[0]), 32'd0);
        check("midreset_align_err", 32'(align_err[0]), 32'd0);
        check("midreset_rdata", rdata[0], 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        access(0, 0, 1, 32'h0000_0020, 32'h0, 32'h0BAD_F00D, 0);
        access(0, 1, 1, 32'h0000_0008, 32'h0000_0001, 32'h0, 0);
        access(0, 0, 1, 32'h0000_0008, 32'h0, 32'h0000_0001, 0);

        access(1, 1, 0, 32'h0000_0004, 32'h1234_5678, 32'h0, 0);
        access(1, 0, 1, 32'h0000_0004, 32'h0, 32'h1234_5678, 0);
        access(1, 0, 1, 32'h0000_0006, 32'h0, 32'h0, 0);
        access(1, 0, 1, 32'h0000_1004, 32'h0, 32'h1234_5678, 0);

        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("resp_queue_left dut%0d", i), 32'(exp_q[i].size()), 32'd0);
            check($sformatf("stall_queue_left dut%0d", i), 32'(stl_q[i].size()), 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
